inst_unpack: RTL and testbench

Decode-side unpacker that takes one 4-instruction group per handshake from the instruction buffer and feeds the 2-wide decode stage. It holds one group, compacts away invalid slots, and emits up to two instructions per cycle in program order. Order is lowest slot first; slot 0 is bits [31:0]. It accepts the next group in the same cycle it issues the last instructions of the current one, so full-mask groups stream with no bubble.

---
 rtl/inst_unpack.sv | 95 +++++++++
 tb/tb_inst_unpack.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/inst_unpack.sv
// rtl/inst_unpack.sv - holds one 4-slot instruction group and issues up to two valid slots per cycle in program order.
// Optional build macro INST_UNPACK_NOP_FILTER_EN drops NOP_WORD slots from the mask at load time.
module inst_unpack (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] inst_4W,
  input  logic [3:0]   inst_4W_valid,
  output logic         out_valid,
  input  logic         next_ready,
  output logic [31:0]  inst0,
  output logic         inst0_valid,
  output logic [1:0]   inst0_slot,
  output logic [31:0]  inst1,
  output logic         inst1_valid,
  output logic [1:0]   inst1_slot
);

  localparam logic [31:0] NOP_WORD = 32'h0340_0000;

  logic [127:0] group_q;
  logic [3:0]   rem_q;
  logic [3:0]   rem_next;
  logic [3:0]   issue_mask;
  logic [3:0]   load_mask;
  logic [1:0]   s0, s1;
  logic         found0, found1;
  logic         out_fire, in_fire;

  // s0 is the lowest remaining slot, s1 the next one above it.
  always_comb begin
    s0 = 2'd0;
    s1 = 2'd0;
    found0 = 1'b0;
    found1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (rem_q[k]) begin
        if (!found0) begin
          s0 = 2'(k);
          found0 = 1'b1;
        end else if (!found1) begin
          s1 = 2'(k);
          found1 = 1'b1;
        end
      end
    end
  end

  always_comb begin
    issue_mask = 4'b0000;
    if (found0) issue_mask[s0] = 1'b1;
    if (found1) issue_mask[s1] = 1'b1;
  end

  assign out_valid   = found0;
  assign inst0_valid = found0;
  assign inst1_valid = found1;
  assign inst0       = found0 ? group_q[{s0, 5'b0} +: 32] : 32'h0;
  assign inst1       = found1 ? group_q[{s1, 5'b0} +: 32] : 32'h0;
  assign inst0_slot  = s0;
  assign inst1_slot  = s1;

  assign out_fire = out_valid & next_ready;
  assign rem_next = out_fire ? (rem_q & ~issue_mask) : rem_q;
  assign in_ready = !flush && (rem_next == 4'b0000);
  assign in_fire  = in_valid & in_ready;

`ifdef INST_UNPACK_NOP_FILTER_EN
  always_comb begin
    load_mask = inst_4W_valid;
    for (int k = 0; k < 4; k++) begin
      if (inst_4W[32*k +: 32] == NOP_WORD) load_mask[k] = 1'b0;
    end
  end
`else
  assign load_mask = inst_4W_valid;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      group_q <= 128'h0;
      rem_q   <= 4'b0000;
    end else if (flush) begin
      rem_q <= 4'b0000;
    end else if (in_fire) begin
      group_q <= inst_4W;
      rem_q   <= load_mask;
    end else begin
      rem_q <= rem_next;
    end
  end

endmodule

// File: tb/tb_inst_unpack.sv
// tb/tb_inst_unpack.sv - directed self-checking bench for inst_unpack.
// Build with INST_UNPACK_NOP_FILTER_EN to exercise the NOP filter expectations.
module tb_inst_unpack;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] inst_4W = '0;
  logic [3:0]   inst_4W_valid = 4'b0000;
  logic         out_valid;
  logic         next_ready = 1'b1;
  logic [31:0]  inst0, inst1;
  logic         inst0_valid, inst1_valid;
  logic [1:0]   inst0_slot, inst1_slot;

  int checks = 0;
  int errors = 0;
  logic [70:0] e;

  localparam logic [31:0] NOP = 32'h0340_0000;
  localparam logic [31:0] A = 32'hAAAA_0001, B = 32'hBBBB_0002, C = 32'hCCCC_0003, D = 32'hDDDD_0004;
  localparam logic [31:0] E = 32'hE0E0_0005, F = 32'hF0F0_0006, G = 32'h1212_0007, H = 32'h3434_0008;
  localparam logic [31:0] W = 32'h5656_0009, Z = 32'h7878_000A, X = 32'h9A9A_000B, Y = 32'hBCBC_000C;

  always #5 clk = ~clk;

  inst_unpack dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .inst_4W(inst_4W), .inst_4W_valid(inst_4W_valid), .out_valid(out_valid),
    .next_ready(next_ready), .inst0(inst0), .inst0_valid(inst0_valid), .inst0_slot(inst0_slot),
    .inst1(inst1), .inst1_valid(inst1_valid), .inst1_slot(inst1_slot)
  );

  wire [70:0] obs = {out_valid, inst0_valid, inst0, inst0_slot, inst1_valid, inst1, inst1_slot};

  function automatic logic [70:0] exp_o(input logic v0, input logic [31:0] w0, input logic [1:0] s0,
                                        input logic v1, input logic [31:0] w1, input logic [1:0] s1);
    return {v0, v0, w0, s0, v1, w1, s1};
  endfunction

  task automatic offer(input logic [31:0] w3, input logic [31:0] w2, input logic [31:0] w1,
                       input logic [31:0] w0, input logic [3:0] m);
    in_valid = 1'b1;
    inst_4W = {w3, w2, w1, w0};
    inst_4W_valid = m;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    checks++; if (obs !== 71'h0) begin errors++; $display("FAIL reset_outputs: got %h exp 0", obs); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
  endtask

  task automatic test_full;
    @(negedge clk); offer(D, C, B, A, 4'b1111); next_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_accept: got %b exp 1", in_ready); end
    @(negedge clk); in_valid = 1'b0; #1;
    e = exp_o(1, A, 0, 1, B, 1);
    checks++; if (obs !== e) begin errors++; $display("FAIL full_c1: got %h exp %h", obs, e); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_c1_ready: got %b exp 0", in_ready); end
    @(negedge clk); #1;
    e = exp_o(1, C, 2, 1, D, 3);
    checks++; if (obs !== e) begin errors++; $display("FAIL full_c2: got %h exp %h", obs, e); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_c2_ready: got %b exp 1", in_ready); end
    @(negedge clk); #1;
    checks++; if (obs !== 71'h0) begin errors++; $display("FAIL full_drain: got %h exp 0", obs); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk); offer(H, G, F, E, 4'b1010); #1;
    @(negedge clk); offer(D, C, B, A, 4'b0100); #1;
    e = exp_o(1, F, 1, 1, H, 3);
    checks++; if (obs !== e) begin errors++; $display("FAIL sparse_1010: got %h exp %h", obs, e); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sparse_ready: got %b exp 1", in_ready); end
    @(negedge clk); in_valid = 1'b0; #1;
    e = exp_o(1, C, 2, 0, 32'h0, 0);
    checks++; if (obs !== e) begin errors++; $display("FAIL sparse_0100: got %h exp %h", obs, e); end
    @(negedge clk); #1;
    checks++; if (obs !== 71'h0) begin errors++; $display("FAIL sparse_drain: got %h exp 0", obs); end
  endtask

  task automatic test_stall;
    @(negedge clk); offer(H, G, F, E, 4'b0111); #1;
    @(negedge clk); offer(D, C, B, A, 4'b1111); next_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      e = exp_o(1, E, 0, 1, F, 1);
      checks++; if (obs !== e) begin errors++; $display("FAIL stall_hold%0d: got %h exp %h", i, obs, e); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready%0d: got %b exp 0", i, in_ready); end
      if (i < 2) begin @(negedge clk); #1; end
    end
    @(negedge clk); next_ready = 1'b1; #1;
    e = exp_o(1, E, 0, 1, F, 1);
    checks++; if (obs !== e) begin errors++; $display("FAIL stall_release: got %h exp %h", obs, e); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_release_ready: got %b exp 0", in_ready); end
    @(negedge clk); in_valid = 1'b0; #1;
    e = exp_o(1, G, 2, 0, 32'h0, 0);
    checks++; if (obs !== e) begin errors++; $display("FAIL stall_tail: got %h exp %h", obs, e); end
    @(negedge clk); #1;
    checks++; if (obs !== 71'h0) begin errors++; $display("FAIL stall_drain: got %h exp 0", obs); end
  endtask

  task automatic test_flush;
    @(negedge clk); offer(D, C, B, A, 4'b1111); #1;
    @(negedge clk); offer(W, W, W, W, 4'b1111); flush = 1'b1; #1;
    e = exp_o(1, A, 0, 1, B, 1);
    checks++; if (obs !== e) begin errors++; $display("FAIL flush_cycle_out: got %h exp %h", obs, e); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_cycle_ready: got %b exp 0", in_ready); end
    @(negedge clk); flush = 1'b0; in_valid = 1'b0; #1;
    checks++; if (obs !== 71'h0) begin errors++; $display("FAIL flush_after: got %h exp 0", obs); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_after_ready: got %b exp 1", in_ready); end
  endtask

  task automatic test_zero_mask;
    @(negedge clk); offer(D, C, B, A, 4'b0000); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL zero_accept: got %b exp 1", in_ready); end
    @(negedge clk); offer(W, W, W, Z, 4'b0001); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_out_valid: got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL zero_next_ready: got %b exp 1", in_ready); end
    @(negedge clk); in_valid = 1'b0; #1;
    e = exp_o(1, Z, 0, 0, 32'h0, 0);
    checks++; if (obs !== e) begin errors++; $display("FAIL zero_next_group: got %h exp %h", obs, e); end
    @(negedge clk); #1;
  endtask

  task automatic test_nop;
    @(negedge clk); offer(Y, NOP, X, NOP, 4'b1111); #1;
    @(negedge clk); in_valid = 1'b0; #1;
`ifdef INST_UNPACK_NOP_FILTER_EN
    e = exp_o(1, X, 1, 1, Y, 3);
    checks++; if (obs !== e) begin errors++; $display("FAIL nop_filtered: got %h exp %h", obs, e); end
    @(negedge clk); #1;
    checks++; if (obs !== 71'h0) begin errors++; $display("FAIL nop_filtered_drain: got %h exp 0", obs); end
`else
    e = exp_o(1, NOP, 0, 1, X, 1);
    checks++; if (obs !== e) begin errors++; $display("FAIL nop_c1: got %h exp %h", obs, e); end
    @(negedge clk); #1;
    e = exp_o(1, NOP, 2, 1, Y, 3);
    checks++; if (obs !== e) begin errors++; $display("FAIL nop_c2: got %h exp %h", obs, e); end
    @(negedge clk); #1;
    checks++; if (obs !== 71'h0) begin errors++; $display("FAIL nop_drain: got %h exp 0", obs); end
`endif
  endtask

  task automatic test_reset_mid;
    @(negedge clk); offer(D, C, B, A, 4'b1111); #1;
    @(negedge clk); in_valid = 1'b0; next_ready = 1'b0; flush = 1'b1; rst = 1'b1; #1;
    @(negedge clk); rst = 1'b0; flush = 1'b0; next_ready = 1'b1; #1;
    checks++; if (obs !== 71'h0) begin errors++; $display("FAIL reset_mid: got %h exp 0", obs); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_ready: got %b exp 1", in_ready); end
  endtask

  initial begin
    test_reset;
    test_full;
    test_back_to_back;
    test_stall;
    test_flush;
    test_zero_mask;
    test_nop;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
